clk_enable_strobe_gen: RTL

// Generates single-cycle clock-enable strobes for downstream enable-gated

---
 rtl/clk_enable_strobe_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/clk_enable_strobe_gen.sv
// clk_enable_strobe_gen
// Produces single-cycle clock-enable strobes at a programmable rate for
// enable-gated registers in the same clock domain. A burst is started with
// start. It runs either for a fixed number of strobes or continuously until
// stop is asserted. The end of every burst is reported with a one-cycle
// done pulse.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   rst             asynchronous active-high reset
//   start           begin a burst (honoured only while idle)
//   stop            abort a running burst
//   div_ratio       strobe period in cycles, 0 behaves as 1
//   burst_len       strobes per burst, 0 means continuous
//   enable_o        registered single-cycle enable strobe
//   busy_o          high while a burst is running
//   done_o          one-cycle pulse when a burst finishes or is aborted
//   strobe_count_o  strobes issued in the current/last burst
module clk_enable_strobe_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [CNT_W-1:0] burst_len,
  output logic             enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] strobe_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             en_q,    en_d;
  logic             done_q,  done_d;
  logic             busy_q,  busy_d;
  logic [DIV_W-1:0] div_eff_s;
  logic             burst_end_s;

  // A zero ratio would never let the prescaler expire, so it is promoted to 1.
  assign div_eff_s   = (div_ratio == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : div_ratio;
  // Set in the cycle right after the last strobe of a finite burst.
  assign burst_end_s = (len_q != {CNT_W{1'b0}}) && (cnt_q == len_q);

  // Next-state, prescaler and output decode.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          div_d   = div_eff_s;
          presc_d = div_eff_s;
          len_d   = burst_len;
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Both stop and burst completion win over a strobe due this edge.
        if (stop || burst_end_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          // The prescaler holds the number of edges left until the next strobe.
          if (presc_q == {{(DIV_W-1){1'b0}}, 1'b1}) begin
            en_d    = 1'b1;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            presc_d = div_q;
          end else begin
            presc_d = presc_q - {{(DIV_W-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= {DIV_W{1'b0}};
      div_q   <= {DIV_W{1'b0}};
      len_q   <= {CNT_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign enable_o       = en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign strobe_count_o = cnt_q;

endmodule
